// File: rtl/debounce_array.sv
// N-channel push-button debouncer: 2-FF synchroniser, stability counter, debounced level,
// press/release pulses and an optional long-press pulse with auto-repeat.
//
// state           | meaning
// RELEASED        | o_state=0, cnt=0: input low and accepted
// CONFIRM_PRESS   | o_state=0, cnt!=0: input high, counting toward acceptance
// PRESSED         | o_state=1, cnt=0: input high and accepted
// CONFIRM_RELEASE | o_state=1, cnt!=0: input low, counting toward acceptance
module debounce_array #(
    parameter int N          = 4,
    parameter int DELAY      = 100000,
    parameter int HOLD       = 0,
    parameter int REPEAT     = 0,
    parameter int ACTIVE_LOW = 0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [N-1:0] i_in,
    output logic [N-1:0] o_state,
    output logic [N-1:0] o_rise,
    output logic [N-1:0] o_fall,
    output logic [N-1:0] o_hold
);

    localparam int CW = (DELAY > 1) ? $clog2(DELAY) : 1;

    logic [N-1:0]  p;
    logic [N-1:0]  s1_q, s2_q;
    logic [N-1:0]  state_q, state_d;
    logic [N-1:0]  rise_q, rise_d;
    logic [N-1:0]  fall_q, fall_d;
    logic [CW-1:0] cnt_q [N];
    logic [CW-1:0] cnt_d [N];

    assign p = (ACTIVE_LOW != 0) ? ~i_in : i_in;

    always_comb begin
        state_d = state_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == state_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CW'(DELAY - 1)) begin
                state_d[i] = ~state_q[i];
                cnt_d[i]   = '0;
                rise_d[i]  = ~state_q[i];
                fall_d[i]  = state_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            state_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            for (int i = 0; i < N; i++) cnt_q[i] <= '0;
        end else begin
            s1_q    <= p;
            s2_q    <= s1_q;
            state_q <= state_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign o_state = state_q;
    assign o_rise  = rise_q;
    assign o_fall  = fall_q;

    generate
        if (HOLD > 0) begin : g_hold
            localparam int HMAX = (HOLD > REPEAT) ? HOLD : REPEAT;
            localparam int HW   = (HMAX > 0) ? $clog2(HMAX + 1) : 1;
            // REPEAT==0 reloads to HOLD, which is the saturation value; REPEAT>HOLD relies
            // on modular wrap, still exactly REPEAT increments back to HOLD-1.
            localparam logic [HW-1:0] RELOAD = HW'(HOLD - REPEAT);

            logic [HW-1:0] hcnt_q [N];
            logic [HW-1:0] hcnt_d [N];
            logic [N-1:0]  hold_q, hold_d;

            always_comb begin
                hold_d = '0;
                for (int i = 0; i < N; i++) begin
                    hcnt_d[i] = hcnt_q[i];
                    if (!state_q[i] || fall_d[i]) begin
                        hcnt_d[i] = '0;
                    end else if (hcnt_q[i] == HW'(HOLD - 1)) begin
                        hold_d[i] = 1'b1;
                        hcnt_d[i] = RELOAD;
                    end else if (!(REPEAT == 0 && hcnt_q[i] == HW'(HOLD))) begin
                        hcnt_d[i] = hcnt_q[i] + HW'(1);
                    end
                end
            end

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    hold_q <= '0;
                    for (int i = 0; i < N; i++) hcnt_q[i] <= '0;
                end else begin
                    hold_q <= hold_d;
                    for (int i = 0; i < N; i++) hcnt_q[i] <= hcnt_d[i];
                end
            end

            assign o_hold = hold_q;
        end else begin : g_no_hold
            assign o_hold = '0;
        end
    endgenerate

endmodule

// File: tb/tb_debounce_array.sv
// Self-checking bench for debounce_array: directed tables, corner sequences and random
// stimulus against a sliding-window reference model; an ACTIVE_LOW twin sees inverted inputs.
module tb_debounce_array;

    localparam int N      = 4;
    localparam int DELAY  = 16;
    localparam int HOLD   = 64;
    localparam int REPEAT = 32;

    logic         clk;
    logic         rst;
    logic [N-1:0] i_in;
    logic [N-1:0] i_in_n;
    logic [N-1:0] st, ri, fa, ho;
    logic [N-1:0] st_n, ri_n, fa_n, ho_n;

    assign i_in_n = ~i_in;

    debounce_array #(.N(N), .DELAY(DELAY), .HOLD(HOLD), .REPEAT(REPEAT), .ACTIVE_LOW(0)) dut (
        .i_clk(clk), .i_rst(rst), .i_in(i_in),
        .o_state(st), .o_rise(ri), .o_fall(fa), .o_hold(ho)
    );

    debounce_array #(.N(N), .DELAY(DELAY), .HOLD(HOLD), .REPEAT(REPEAT), .ACTIVE_LOW(1)) dut_n (
        .i_clk(clk), .i_rst(rst), .i_in(i_in_n),
        .o_state(st_n), .o_rise(ri_n), .o_fall(fa_n), .o_hold(ho_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: level accepted once the last DELAY synchronised samples all disagree
    logic [N-1:0] hist[$];
    logic [N-1:0] m_state, e_rise, e_fall, e_hold;
    int           t_since [N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int j = 0; j < DELAY + 2; j++) hist.push_front('0);
        m_state = '0;
        e_rise  = '0;
        e_fall  = '0;
        e_hold  = '0;
        for (int c = 0; c < N; c++) t_since[c] = 0;
    endtask

    task automatic model_edge(input logic [N-1:0] in);
        logic [N-1:0] v;
        logic         differs;
        hist.push_front(in);
        if (hist.size() > DELAY + 2) void'(hist.pop_back());
        e_rise = '0;
        e_fall = '0;
        e_hold = '0;
        for (int c = 0; c < N; c++) begin
            // samples seen by the logic at the last DELAY edges were taken 2..DELAY+1 edges ago
            differs = 1'b1;
            for (int j = 2; j <= DELAY + 1; j++) begin
                v = hist[j];
                if (v[c] == m_state[c]) differs = 1'b0;
            end
            if (differs) begin
                if (m_state[c]) e_fall[c] = 1'b1;
                else            e_rise[c] = 1'b1;
            end
            if (m_state[c] && !e_fall[c]) begin
                t_since[c]++;
                if (t_since[c] == HOLD ||
                    (REPEAT > 0 && t_since[c] > HOLD && (t_since[c] - HOLD) % REPEAT == 0))
                    e_hold[c] = 1'b1;
            end
            if (e_rise[c]) t_since[c] = 0;
        end
        m_state = m_state ^ e_rise ^ e_fall;
    endtask

    task automatic tick(input logic [N-1:0] in);
        i_in = in;
        @(posedge clk);
        model_edge(in);
        #1;
        chk("state",   32'(st),   32'(m_state));
        chk("rise",    32'(ri),   32'(e_rise));
        chk("fall",    32'(fa),   32'(e_fall));
        chk("hold",    32'(ho),   32'(e_hold));
        chk("state_n", 32'(st_n), 32'(m_state));
        chk("rise_n",  32'(ri_n), 32'(e_rise));
        chk("fall_n",  32'(fa_n), 32'(e_fall));
        chk("hold_n",  32'(ho_n), 32'(e_hold));
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, 32'({st, ri, fa, ho}), 32'd0);
        chk({name, "_n"}, 32'({st_n, ri_n, fa_n, ho_n}), 32'd0);
    endtask

    typedef struct {
        logic [N-1:0] in;
        int           cycles;
        logic [N-1:0] st;
        int           rises;
        int           falls;
        int           holds;
    } vec_t;

    vec_t tbl [15];

    initial begin
        int n;
        int rise_tot, fall_tot, hold_tot;
        int runleft [N];
        logic [N-1:0] rin;

        tbl[0]  = '{4'b0000,  20, 4'b0000, 0, 0, 0};
        tbl[1]  = '{4'b0010,   3, 4'b0000, 0, 0, 0};
        tbl[2]  = '{4'b0000,   3, 4'b0000, 0, 0, 0};
        tbl[3]  = '{4'b0010,   7, 4'b0000, 0, 0, 0};
        tbl[4]  = '{4'b0000,   3, 4'b0000, 0, 0, 0};
        tbl[5]  = '{4'b0010,  12, 4'b0000, 0, 0, 0};
        tbl[6]  = '{4'b0000,   3, 4'b0000, 0, 0, 0};
        tbl[7]  = '{4'b0010,  30, 4'b0010, 1, 0, 0};
        tbl[8]  = '{4'b0000,  30, 4'b0000, 1, 1, 0};
        tbl[9]  = '{4'b0100, 218, 4'b0100, 2, 1, 5};
        tbl[10] = '{4'b0000,  30, 4'b0000, 2, 2, 5};
        tbl[11] = '{4'b1111,  30, 4'b1111, 6, 2, 5};
        tbl[12] = '{4'b0111,  15, 4'b1111, 6, 2, 5};
        tbl[13] = '{4'b1111,  30, 4'b1111, 6, 2, 5};
        tbl[14] = '{4'b0000,  30, 4'b0000, 6, 6, 9};

        rst  = 1'b1;
        i_in = '0;
        model_reset();
        #13;
        chk_all_zero("reset_out");
        @(negedge clk);
        rst = 1'b0;

        // clean step on ch0: press and release each take DELAY+2 edges
        for (int k = 0; k < 5; k++) tick(4'b0000);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            tick(4'b0001);
            n++;
            if (ri[0]) break;
        end
        chk("step_rise_lat", 32'(n), 32'(DELAY + 2));
        chk("step_rise_state", 32'(st[0]), 32'd1);
        for (int k = 0; k < 5; k++) tick(4'b0001);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            tick(4'b0000);
            n++;
            if (fa[0]) break;
        end
        chk("step_fall_lat", 32'(n), 32'(DELAY + 2));
        chk("step_fall_state", 32'(st[0]), 32'd0);
        for (int k = 0; k < 5; k++) tick(4'b0000);

        // bounce, long press with repeat, simultaneous step and short glitch
        rise_tot = 0;
        fall_tot = 0;
        hold_tot = 0;
        for (int r = 0; r < 15; r++) begin
            for (int k = 0; k < tbl[r].cycles; k++) begin
                tick(tbl[r].in);
                rise_tot += $countones(ri);
                fall_tot += $countones(fa);
                hold_tot += $countones(ho);
                if (r == 11 && ri != 4'b0000) chk("simul_rise", 32'(ri), 32'hF);
            end
            chk($sformatf("tbl%0d_state", r), 32'(st), 32'(tbl[r].st));
            chk($sformatf("tbl%0d_rises", r), 32'(rise_tot), 32'(tbl[r].rises));
            chk($sformatf("tbl%0d_falls", r), 32'(fall_tot), 32'(tbl[r].falls));
            chk($sformatf("tbl%0d_holds", r), 32'(hold_tot), 32'(tbl[r].holds));
        end

        // asynchronous reset mid-count, with ch1 already pressed
        for (int k = 0; k < 30; k++) tick(4'b0010);
        chk("pre_rst_state", 32'(st), 32'h2);
        for (int k = 0; k < 11; k++) tick(4'b0011);
        #3 rst = 1'b1;
        #1 chk_all_zero("mid_rst_out");
        #1 rst = 1'b0;
        model_reset();
        n = 0;
        for (int k = 0; k < 40; k++) begin
            tick(4'b0011);
            n++;
            if (ri != 4'b0000) break;
        end
        chk("rst_rise_lat", 32'(n), 32'(DELAY + 2));
        chk("rst_rise_val", 32'(ri), 32'h3);

        // random per-channel runs of 1..90 cycles
        rin = i_in;
        for (int c = 0; c < N; c++) runleft[c] = $urandom_range(1, 90);
        for (int k = 0; k < 4000; k++) begin
            for (int c = 0; c < N; c++) begin
                runleft[c]--;
                if (runleft[c] <= 0) begin
                    rin[c]     = ~rin[c];
                    runleft[c] = $urandom_range(1, 90);
                end
            end
            tick(rin);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
